// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera pattern emitter.
//   - FSM state encoding for the frame sequencer
//   - pattern mode codes
//   - RGB565 colour constants for the bars and the moving square
//   - per-axis square motion helper (bounce between 0 and a limit)
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } cam_state_e;

    localparam logic [1:0] MODE_BARS   = 2'd0;
    localparam logic [1:0] MODE_SOLID  = 2'd1;
    localparam logic [1:0] MODE_RAMP   = 2'd2;
    localparam logic [1:0] MODE_SQUARE = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] BLACK = 16'h0000;

    // One axis of the square: position plus direction (neg=1 moving towards 0).
    typedef struct packed {
        logic signed [11:0] pos;
        logic               neg;
    } axis_t;

    localparam axis_t AXIS_HOME = '{pos: 12'sd0, neg: 1'b0};

    // Colour of bar idx, left to right.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] col;
        case (idx)
            3'd0:    col = BAR_WHITE;
            3'd1:    col = BAR_YELLOW;
            3'd2:    col = BAR_CYAN;
            3'd3:    col = BAR_GREEN;
            3'd4:    col = BAR_MAGENTA;
            3'd5:    col = BAR_RED;
            3'd6:    col = BAR_BLUE;
            3'd7:    col = BAR_BLACK;
            default: col = BAR_BLACK;
        endcase
        return col;
    endfunction

    // Advance one axis by step, clamping at 0 / limit and reversing there.
    function automatic axis_t axis_step(input axis_t cur,
                                        input logic signed [11:0] limit,
                                        input logic signed [11:0] step);
        axis_t              nxt_axis;
        logic signed [11:0] nxt;
        if (!cur.neg) begin
            nxt = cur.pos + step;
            if (nxt >= limit) begin
                nxt_axis.pos = limit;
                nxt_axis.neg = 1'b1;
            end else begin
                nxt_axis.pos = nxt;
                nxt_axis.neg = 1'b0;
            end
        end else begin
            nxt = cur.pos - step;
            if (nxt <= 12'sd0) begin
                nxt_axis.pos = 12'sd0;
                nxt_axis.neg = 1'b0;
            end else begin
                nxt_axis.pos = nxt;
                nxt_axis.neg = 1'b1;
            end
        end
        return nxt_axis;
    endfunction

endpackage

// File: rtl/cam_pattern_pixel.sv
// cam_pattern_pixel: combinational RGB565 pixel generator.
// Ports:
//   x_i, y_i      pixel column / active line index
//   mode_i        pattern mode latched for the frame
//   solid_i       solid colour latched for the frame
//   bx_i, by_i    square origin for the frame
//   pixel_o       RGB565 pixel value
module cam_pattern_pixel
    import cam_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int BALL_SIZE = 16
) (
    input  logic [11:0] x_i,
    input  logic [11:0] y_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] solid_i,
    input  logic [11:0] bx_i,
    input  logic [11:0] by_i,
    output logic [15:0] pixel_o
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [11:0] bar_idx_s;
    logic        in_sq_s;

    // Bar index and square membership for the current pixel.
    always_comb begin
        bar_idx_s = x_i / 12'(BAR_W);
        in_sq_s   = (x_i >= bx_i) && (x_i < (bx_i + 12'(BALL_SIZE))) &&
                    (y_i >= by_i) && (y_i < (by_i + 12'(BALL_SIZE)));
    end

    // Pattern select.
    always_comb begin
        pixel_o = BLACK;
        case (mode_i)
            MODE_BARS: begin
                if (bar_idx_s < 12'd8) begin
                    pixel_o = bar_color(bar_idx_s[2:0]);
                end else begin
                    pixel_o = BLACK;
                end
            end
            MODE_SOLID:  pixel_o = solid_i;
            MODE_RAMP:   pixel_o = {x_i[4:0], y_i[5:0], x_i[4:0]};
            MODE_SQUARE: begin
                if (in_sq_s) begin
                    pixel_o = RED;
                end else begin
                    pixel_o = BLACK;
                end
            end
            default:     pixel_o = BLACK;
        endcase
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: OV7670-style sensor emitter producing RGB565 test frames.
// Ports:
//   clk          system clock
//   res          asynchronous active-high reset
//   enable       allow new frames to start
//   mode         0 bars, 1 solid, 2 ramp, 3 moving square
//   solid_color  RGB565 colour for mode 1
//   pclk         pixel clock (toggles every PCLK_DIV clks)
//   href         line valid, high during active bytes
//   vsync        frame sync, high for the whole VSYNC segment
//   data         byte stream, high byte of each pixel first
//   frame_start  one-clk pulse when a frame begins
//   frame_count  completed frames (wrapping)
// Sensor outputs change only on the clk where pclk falls, so they are
// stable across every pclk rising edge.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2,
    parameter int BALL_SIZE   = 16,
    parameter int BALL_STEP   = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_color,
    output logic        pclk,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  data,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam logic [11:0] LAST_BYTE   = 12'(2*H_ACTIVE + H_BLANK - 1);
    localparam logic [11:0] ACT_BYTES   = 12'(2*H_ACTIVE);
    localparam logic [11:0] DIV_LAST    = 12'(PCLK_DIV - 1);
    localparam logic [11:0] VSYNC_LAST  = 12'(VSYNC_LINES - 1);
    localparam logic [11:0] VBACK_LAST  = 12'(V_BACK - 1);
    localparam logic [11:0] ACTIVE_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] VFRONT_LAST = 12'(V_FRONT - 1);
    localparam logic signed [11:0] LIM_X = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] LIM_Y = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] STEP  = 12'(BALL_STEP);

    cam_state_e  state_q, state_d;
    logic [11:0] div_q;
    logic        pclk_q;
    logic        div_tick_s, fall_tick_s;
    logic [11:0] byte_q, byte_d, line_q, line_d;
    logic        line_end_s, seg_last_s, seg_done_s;
    logic        href_q, href_d, vsync_q, vsync_d;
    logic [7:0]  data_q, data_d;
    logic        frame_start_q, frame_start_d, frame_done_s;
    logic [15:0] frame_count_q;
    logic [1:0]  mode_q;
    logic [15:0] solid_q;
    axis_t       ax_q, ay_q;
    logic        started_q;
    logic [11:0] pix_x_s;
    logic [15:0] pixel_s;

    // Divider tick and the pclk falling-edge tick.
    always_comb begin
        div_tick_s  = (div_q == DIV_LAST);
        fall_tick_s = div_tick_s && pclk_q;
    end

    // Free-running pclk divider.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            div_q  <= 12'd0;
            pclk_q <= 1'b0;
        end else if (div_tick_s) begin
            div_q  <= 12'd0;
            pclk_q <= ~pclk_q;
        end else begin
            div_q  <= div_q + 12'd1;
        end
    end

    // End-of-line and end-of-segment detection for the current state.
    always_comb begin
        line_end_s = (byte_q == LAST_BYTE);
        case (state_q)
            ST_VSYNC:  seg_last_s = (line_q == VSYNC_LAST);
            ST_VBACK:  seg_last_s = (line_q == VBACK_LAST);
            ST_ACTIVE: seg_last_s = (line_q == ACTIVE_LAST);
            ST_VFRONT: seg_last_s = (line_q == VFRONT_LAST);
            default:   seg_last_s = 1'b0;
        endcase
        seg_done_s = line_end_s && seg_last_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE reacts on any fall tick, others at segment end.
    always_comb begin
        state_d = state_q;
        if (fall_tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_VSYNC;
                    else        state_d = ST_IDLE;
                end
                ST_VSYNC: begin
                    if (seg_done_s) state_d = ST_VBACK;
                    else            state_d = ST_VSYNC;
                end
                ST_VBACK: begin
                    if (seg_done_s) state_d = ST_ACTIVE;
                    else            state_d = ST_VBACK;
                end
                ST_ACTIVE: begin
                    if (seg_done_s) state_d = ST_VFRONT;
                    else            state_d = ST_ACTIVE;
                end
                ST_VFRONT: begin
                    if (seg_done_s && enable)  state_d = ST_VSYNC;
                    else if (seg_done_s)       state_d = ST_IDLE;
                    else                       state_d = ST_VFRONT;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Byte and line counters; line counts restart in every segment.
    always_comb begin
        byte_d = byte_q;
        line_d = line_q;
        if (fall_tick_s) begin
            if (state_q == ST_IDLE) begin
                byte_d = 12'd0;
                line_d = 12'd0;
            end else if (line_end_s) begin
                byte_d = 12'd0;
                if (seg_done_s) line_d = 12'd0;
                else            line_d = line_q + 12'd1;
            end else begin
                byte_d = byte_q + 12'd1;
                line_d = line_q;
            end
        end else begin
            byte_d = byte_q;
            line_d = line_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            byte_q <= 12'd0;
            line_q <= 12'd0;
        end else begin
            byte_q <= byte_d;
            line_q <= line_d;
        end
    end

    // Pixel column of the byte about to be driven.
    assign pix_x_s = {1'b0, byte_d[11:1]};

    cam_pattern_pixel #(
        .H_ACTIVE  (H_ACTIVE),
        .BALL_SIZE (BALL_SIZE)
    ) u_pixel (
        .x_i     (pix_x_s),
        .y_i     (line_d),
        .mode_i  (mode_q),
        .solid_i (solid_q),
        .bx_i    (ax_q.pos),
        .by_i    (ay_q.pos),
        .pixel_o (pixel_s)
    );

    // FSM outputs, computed from the state being entered so they line up
    // with the counters on the same fall tick.
    always_comb begin
        frame_start_d = fall_tick_s && (state_q != ST_VSYNC) && (state_d == ST_VSYNC);
        frame_done_s  = fall_tick_s && (state_q == ST_VFRONT) && (state_d != ST_VFRONT);
        if (fall_tick_s) begin
            vsync_d = (state_d == ST_VSYNC);
            href_d  = (state_d == ST_ACTIVE) && (byte_d < ACT_BYTES);
            if (href_d) begin
                data_d = byte_d[0] ? pixel_s[7:0] : pixel_s[15:8];
            end else begin
                data_d = 8'h00;
            end
        end else begin
            vsync_d = vsync_q;
            href_d  = href_q;
            data_d  = data_q;
        end
    end

    // Registered sensor outputs and frame counter.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            if (frame_done_s) begin
                frame_count_q <= frame_count_q + 16'd1;
            end else begin
                frame_count_q <= frame_count_q;
            end
        end
    end

    // Per-frame latch of pattern inputs and square motion; the first frame
    // after reset keeps the square at the origin.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            mode_q    <= MODE_BARS;
            solid_q   <= 16'h0000;
            ax_q      <= AXIS_HOME;
            ay_q      <= AXIS_HOME;
            started_q <= 1'b0;
        end else if (frame_start_d) begin
            mode_q    <= mode;
            solid_q   <= solid_color;
            started_q <= 1'b1;
            if (started_q) begin
                ax_q <= axis_step(ax_q, LIM_X, STEP);
                ay_q <= axis_step(ay_q, LIM_Y, STEP);
            end else begin
                ax_q <= ax_q;
                ay_q <= ay_q;
            end
        end else begin
            mode_q    <= mode_q;
            solid_q   <= solid_q;
        end
    end

    assign pclk        = pclk_q;
    assign href        = href_q;
    assign vsync       = vsync_q;
    assign data        = data_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
